// File: rtl/count_capture.sv
// count_capture: timestamps rising edges of TRIG as {wrap count, F} into a
// small FIFO. The wrap count extends the upstream counter by counting COUT
// pulses. Captures into a full FIFO are dropped and flagged on OVERFLOW
// unless a pop frees the head slot at the same edge.
module count_capture #(
   parameter int WIDTH = 3,
   parameter int WRAPW = 4,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       CLRN,
   input  logic [WIDTH-1:0]           F,
   input  logic                       COUT,
   input  logic                       TRIG,
   input  logic                       RD_READY,
   input  logic                       CLR_OVF,
   output logic                       RD_VALID,
   output logic [WRAPW+WIDTH-1:0]     RD_DATA,
   output logic [$clog2(DEPTH):0]     LEVEL,
   output logic                       OVERFLOW
);

   localparam int AW  = $clog2(DEPTH);
   localparam int TSW = WRAPW + WIDTH;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WRAPW-1:0] wrap_cnt;
   logic             trig_q;
   logic [TSW-1:0]   mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic             ovf;

   logic capture;
   logic pop;
   logic full;
   logic accept;
   logic drop;

   // Edge detect on TRIG; a full FIFO still accepts when the head leaves at
   // the same edge, because the freed slot is the one being written.
   assign capture = TRIG & ~trig_q;
   assign pop     = RD_VALID & RD_READY;
   assign full    = (level == FULL_LVL);
   assign accept  = capture & (~full | pop);
   assign drop    = capture & full & ~pop;

   // Outputs derive from reset-cleared state, so CLRN zeroes them at once.
   assign RD_VALID = (level != '0);
   assign RD_DATA  = RD_VALID ? mem[rd_ptr] : '0;
   assign LEVEL    = level;
   assign OVERFLOW = ovf;

   // Wrap counter and TRIG history; the captured wrap count is the value
   // before any increment at the same edge.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         wrap_cnt <= '0;
         trig_q   <= 1'b0;
      end else begin
         if (COUT) wrap_cnt <= wrap_cnt + WRAPW'(1);
         trig_q <= TRIG;
      end
   end

   // Entry storage; stale contents are unreachable once pointers reset.
   always_ff @(posedge CLK) begin
      if (accept) mem[wr_ptr] <= {wrap_cnt, F};
   end

   // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow; a drop at the same edge as a clear keeps it set.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN)        ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (CLR_OVF) ovf <= 1'b0;
   end

endmodule
